pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage that sits directly downstream of the jump-target lookup table. Each cycle it selects the next program counter from one of these sources:
- the incrementer
- the LUT-supplied absolute target
- a 4-entry return-address stack

It also runs the start/done request/acknowledge handshake with the testbench/top level. Its registered prog_ctr drives instruction-memory addressing.

Parameters:
D, 10, program-counter width; equals width of the LUT target bus.
RAS_DEPTH, 4, return-address stack entries (power of 2, 2..8).

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  run request (level); held high by requester until done seen.
stall  input  1  freeze PC, stack and state this cycle.
jump_en  input  1  unconditional absolute jump to target.
branch_en  input  1  conditional branch instruction present.
taken  input  1  branch condition true (qualified by branch_en).
call_en  input  1  push return address, jump to target.
ret_en  input  1  pop return address into PC.
halt_en  input  1  end-of-program instruction.
target  input  D  absolute target from LUT (combinational, same cycle).
prog_ctr  output  D  current program counter (registered).
running  output  1  high in RUN state.
done  output  1  high in DONE state (acknowledge).
ras_overflow  output  1  sticky: push onto full stack occurred.
ras_underflow  output  1  sticky: pop from empty stack occurred.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, prog_ctr=0, running=0, done=0, both flags=0.
  - Stack count=0; stack contents don't-care.
  - Asserting reset mid-RUN aborts immediately; there is no deferred completion.
- All outputs are registered; there are no combinational input-to-output paths.
- States:
  - IDLE: prog_ctr held 0. start=1 moves to RUN next edge, with prog_ctr=0, stack emptied, flags cleared. stall is ignored in IDLE.
  - RUN: running=1. Next-PC priority, highest first:
    1. stall: hold everything.
    2. halt_en: prog_ctr holds, go to DONE.
    3. ret_en: pop.
    4. call_en: push.
    5. jump_en: prog_ctr<=target.
    6. branch_en&taken: prog_ctr<=target.
    7. otherwise: prog_ctr<=prog_ctr+1.
  - DONE: done=1, running=0, prog_ctr frozen at the halt address. start=0 moves to IDLE next edge (done drops, prog_ctr<=0). While start stays 1, remain in DONE.
- branch_en with taken=0 is plain increment.
- Simultaneous enables resolve strictly by the priority above; lower-priority enables are discarded with no side effect (e.g. call+ret gives a pop only, no push).
- Arithmetic: +1 is modulo 2^D; 2^D-1 wraps to 0 without flagging.
- Call:
  - Push (prog_ctr+1) mod 2^D, then prog_ctr<=target.
  - If count==RAS_DEPTH: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_overflow<=1.
- Return:
  - If count>0: prog_ctr<=top entry, count-1.
  - If count==0: prog_ctr<=prog_ctr+1, ras_underflow<=1.
- Sticky flags hold until the next IDLE->RUN transition or reset.
- Latency: a control input sampled at edge N is reflected in prog_ctr after edge N; one instruction per cycle with no bubbles.

Test Plan:
- Reset, start=1 one cycle, no enables for 5 cycles -> running=1; prog_ctr 0,1,2,3,4,5 on successive edges; done=0.
- At prog_ctr=3: jump_en=1, target=80 -> next prog_ctr=80. Then branch_en=1, taken=0 -> 81. Then branch_en=1, taken=1, target=68 -> 68.
- At prog_ctr=5: call_en, target=58 -> 58. Increment to 60, ret_en -> 6. Then ret_en again -> prog_ctr=7, ras_underflow=1, sticky through later cycles.
- Five nested calls from 10,20,30,40,50 (targets 20,30,40,50,70) -> ras_overflow=1. Four rets then return 51,41,31,21. A fifth ret gives underflow.
- Jump to target=1023, no enable -> prog_ctr=0. Stall=1 for 3 cycles at prog_ctr=113 with halt_en=1 -> prog_ctr holds 113 and state stays RUN. Stall=0 -> DONE, done=1, prog_ctr=113. start=0 -> IDLE, done=0, prog_ctr=0.
- Mid-RUN at prog_ctr=42 with a pending stack entry, pulse reset_n=0 between edges -> outputs go to reset values immediately. Restart -> prog_ctr=0; ret_en -> underflow (stack empty).

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Bus between the fetch controller and its requester: run handshake,
// per-cycle control enables, LUT target in, program counter and status out.
interface pc_fetch_ctrl_if #(
    parameter int D = 10
);
    logic         start;
    logic         stall;
    logic         jump_en;
    logic         branch_en;
    logic         taken;
    logic         call_en;
    logic         ret_en;
    logic         halt_en;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         running;
    logic         done;
    logic         ras_overflow;
    logic         ras_underflow;

    modport master (
        output start, stall, jump_en, branch_en, taken, call_en, ret_en, halt_en, target,
        input  prog_ctr, running, done, ras_overflow, ras_underflow
    );

    modport slave (
        input  start, stall, jump_en, branch_en, taken, call_en, ret_en, halt_en, target,
        output prog_ctr, running, done, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-control stage: picks the next PC from the incrementer,
// the LUT target or a circular return-address stack, and runs start/done.
module pc_fetch_ctrl #(
    parameter int D         = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_fetch_ctrl_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [D-1:0]    r_pc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_top;
    logic            r_ovf;
    logic            r_unf;
    logic [D-1:0]    r_stack [RAS_DEPTH];

    state_t          w_stateNext;
    logic [D-1:0]    w_pcNext;
    logic [D-1:0]    w_pcInc;
    logic [CW-1:0]   w_countNext;
    logic [PW-1:0]   w_topNext;
    logic [PW-1:0]   w_popIdx;
    logic            w_ovfNext;
    logic            w_unfNext;
    logic            w_push;

    assign w_pcInc  = r_pc + D'(1);
    assign w_popIdx = r_top - PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_count <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_count <= w_countNext;
            r_top   <= w_topNext;
            r_ovf   <= w_ovfNext;
            r_unf   <= w_unfNext;
        end
    end

    // r_top is the next write slot; when full it already points at the oldest entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_top] <= w_pcInc;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_countNext = r_count;
        w_topNext   = r_top;
        w_ovfNext   = r_ovf;
        w_unfNext   = r_unf;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext = RUN;
                    w_pcNext    = '0;
                    w_countNext = '0;
                    w_topNext   = '0;
                    w_ovfNext   = 1'b0;
                    w_unfNext   = 1'b0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt_en) begin
                        w_stateNext = DONE;
                    end else if (bus.ret_en) begin
                        if (r_count != '0) begin
                            w_pcNext    = r_stack[w_popIdx];
                            w_countNext = r_count - CW'(1);
                            w_topNext   = w_popIdx;
                        end else begin
                            w_pcNext  = w_pcInc;
                            w_unfNext = 1'b1;
                        end
                    end else if (bus.call_en) begin
                        w_push    = 1'b1;
                        w_topNext = r_top + PW'(1);
                        w_pcNext  = bus.target;
                        if (r_count == FULL_COUNT) begin
                            w_ovfNext = 1'b1;
                        end else begin
                            w_countNext = r_count + CW'(1);
                        end
                    end else if (bus.jump_en || (bus.branch_en && bus.taken)) begin
                        w_pcNext = bus.target;
                    end else begin
                        w_pcNext = w_pcInc;
                    end
                end
            end
            DONE: begin
                if (!bus.start) begin
                    w_stateNext = IDLE;
                    w_pcNext    = '0;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_pcNext    = '0;
            end
        endcase
    end

    assign bus.prog_ctr      = r_pc;
    assign bus.running       = (r_state == RUN);
    assign bus.done          = (r_state == DONE);
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;
endmodule
